// File: rtl/uctl_evt_queue.sv
`default_nettype none
// ============================================================================
//  Module      : uctl_evt_queue
//  Description : Core-clock event queue behind the pulse-stretcher CDC stage.
//                Buffers single-cycle event pulses and their data words in a
//                small show-ahead FIFO. It raises a registered, coalesced
//                interrupt and records drops in a sticky overflow flag,
//                because the producer cannot be stalled.
//  Options     : UCTL_EVTQ_TIMEOUT_EN - when defined, adds an age counter.
//                The interrupt then also fires when the head entry has
//                waited TIMEOUT cycles.
//  Revision    : 1.0 - initial release
// ============================================================================
module uctl_evt_queue #(
    parameter int DATA_WD = 8,   // event data word width
    parameter int DEPTH   = 4,   // FIFO entries, power of two, >= 2
    parameter int CNT_WD  = 3,   // log2(DEPTH)+1
    parameter int TIMEOUT = 255  // age limit in cycles, >= 1
) (
    input  logic               clock,
    input  logic               clockRst,
    input  logic               evtValid,
    input  logic [DATA_WD-1:0] evtData,
    input  logic               rdReq,
    output logic               rdValid,
    output logic [DATA_WD-1:0] rdData,
    output logic [CNT_WD-1:0]  count,
    output logic               overflow,
    input  logic               ovfClr,
    input  logic [CNT_WD-1:0]  coalThresh,
    output logic               irq
);

    // ------------------------------------------------------------------------
    // Derived constants
    // ------------------------------------------------------------------------
    localparam int                PTR_WD   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_WD-1:0] c_depth  = CNT_WD'(DEPTH);
    localparam logic [CNT_WD-1:0] c_cntOne = CNT_WD'(1);
    localparam logic [PTR_WD-1:0] c_ptrOne = PTR_WD'(1);

    // ------------------------------------------------------------------------
    // Storage and bookkeeping registers
    // ------------------------------------------------------------------------
    logic [DATA_WD-1:0] r_mem [DEPTH];
    logic [PTR_WD-1:0]  r_wrPtr;
    logic [PTR_WD-1:0]  r_rdPtr;
    logic [CNT_WD-1:0]  r_count;
    logic               r_overflow;
    logic               r_irq;

    // ------------------------------------------------------------------------
    // Handshake decode
    // ------------------------------------------------------------------------
    logic               w_notEmpty;
    logic               w_full;
    logic               w_pop;
    logic               w_push;
    logic               w_drop;
    logic [CNT_WD-1:0]  w_thresh;
    logic               w_countIrq;
    logic               w_ageExpired;

    assign w_notEmpty = (r_count != '0);
    assign w_full     = (r_count == c_depth);

    // A pop is honoured only while something is queued.
    assign w_pop      = rdReq && w_notEmpty;

    // A full queue still accepts an event when the head leaves this cycle:
    // the freed slot is reused and the count stays at DEPTH.
    assign w_push     = evtValid && (!w_full || w_pop);

    // Without a slot to land in, the event is lost and only flagged.
    assign w_drop     = evtValid && w_full && !w_pop;

    // A threshold of zero would make the interrupt fire on an empty queue,
    // so it is promoted to one.
    assign w_thresh   = (coalThresh == '0) ? c_cntOne : coalThresh;
    assign w_countIrq = (r_count >= w_thresh);

    // ------------------------------------------------------------------------
    // Outputs are driven from registers only
    // ------------------------------------------------------------------------
    assign rdValid  = w_notEmpty;
    assign rdData   = w_notEmpty ? r_mem[r_rdPtr] : '0;
    assign count    = r_count;
    assign overflow = r_overflow;
    assign irq      = r_irq;

    // Data array write; contents are don't-care after reset since count gates rdData.
    always_ff @(posedge clock) begin
        if (w_push) begin
            r_mem[r_wrPtr] <= evtData;
        end
    end

    // Write pointer advances on every accepted event, wrapping modulo DEPTH.
    always_ff @(posedge clock or posedge clockRst) begin
        if (clockRst) begin
            r_wrPtr <= '0;
        end else if (w_push) begin
            r_wrPtr <= r_wrPtr + c_ptrOne;
        end
    end

    // Read pointer advances on every honoured pop, wrapping modulo DEPTH.
    always_ff @(posedge clock or posedge clockRst) begin
        if (clockRst) begin
            r_rdPtr <= '0;
        end else if (w_pop) begin
            r_rdPtr <= r_rdPtr + c_ptrOne;
        end
    end

    // Occupancy: simultaneous push and pop leave it unchanged, even when full.
    always_ff @(posedge clock or posedge clockRst) begin
        if (clockRst) begin
            r_count <= '0;
        end else if (w_push && !w_pop) begin
            r_count <= r_count + c_cntOne;
        end else if (w_pop && !w_push) begin
            r_count <= r_count - c_cntOne;
        end
    end

    // Sticky overflow: a drop in the same cycle as a clear keeps it set.
    always_ff @(posedge clock or posedge clockRst) begin
        if (clockRst) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end else if (ovfClr) begin
            r_overflow <= 1'b0;
        end
    end

`ifdef UCTL_EVTQ_TIMEOUT_EN
    // ------------------------------------------------------------------------
    // Age of the oldest entry: restarts whenever the queue is empty or the
    // head is consumed, and saturates at the limit so the interrupt holds.
    // ------------------------------------------------------------------------
    if (1) begin : g_ageCounter
        localparam int                AGE_WD    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
        localparam logic [AGE_WD-1:0] c_timeout = AGE_WD'(TIMEOUT);
        localparam logic [AGE_WD-1:0] c_ageOne  = AGE_WD'(1);

        logic [AGE_WD-1:0] r_age;

        // Age counter: clear on empty or pop, otherwise count up to the limit.
        always_ff @(posedge clock or posedge clockRst) begin
            if (clockRst) begin
                r_age <= '0;
            end else if (!w_notEmpty || w_pop) begin
                r_age <= '0;
            end else if (r_age != c_timeout) begin
                r_age <= r_age + c_ageOne;
            end
        end

        assign w_ageExpired = (r_age == c_timeout);
    end
`else
    // Without the age counter the timeout term never contributes.
    assign w_ageExpired = 1'b0;

    // Keeps the otherwise idle TIMEOUT parameter referenced.
    logic [31:0] w_unusedTimeout;
    assign w_unusedTimeout = 32'(TIMEOUT);
`endif

    // Interrupt register: one-cycle lag behind count (and age) by construction.
    always_ff @(posedge clock or posedge clockRst) begin
        if (clockRst) begin
            r_irq <= 1'b0;
        end else begin
            r_irq <= w_countIrq || w_ageExpired;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uctl_evt_queue.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uctl_evt_queue
//  Description : Directed self-checking bench for uctl_evt_queue. Covers
//                reset, coalescing, overflow, full push-with-pop, threshold
//                zero, empty pop and the optional timeout interrupt
//                (UCTL_EVTQ_TIMEOUT_EN).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uctl_evt_queue;

    localparam int DATA_WD = 8;
    localparam int DEPTH   = 4;
    localparam int CNT_WD  = 3;
    localparam int TIMEOUT = 10;

    logic               clock;
    logic               clockRst;
    logic               evtValid;
    logic [DATA_WD-1:0] evtData;
    logic               rdReq;
    logic               rdValid;
    logic [DATA_WD-1:0] rdData;
    logic [CNT_WD-1:0]  count;
    logic               overflow;
    logic               ovfClr;
    logic [CNT_WD-1:0]  coalThresh;
    logic               irq;

    int nChecks = 0;
    int nFail   = 0;

    uctl_evt_queue #(
        .DATA_WD (DATA_WD),
        .DEPTH   (DEPTH),
        .CNT_WD  (CNT_WD),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clock      (clock),
        .clockRst   (clockRst),
        .evtValid   (evtValid),
        .evtData    (evtData),
        .rdReq      (rdReq),
        .rdValid    (rdValid),
        .rdData     (rdData),
        .count      (count),
        .overflow   (overflow),
        .ovfClr     (ovfClr),
        .coalThresh (coalThresh),
        .irq        (irq)
    );

    // 10 time-unit clock, rising edges at 5, 15, 25, ...
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Advance past the next rising edge and settle before sampling.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nChecks++;
        assert (obs === exp) else begin
            nFail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        clockRst   = 1'b1;
        evtValid   = 1'b0;
        evtData    = '0;
        rdReq      = 1'b0;
        ovfClr     = 1'b0;
        coalThresh = 3'd2;

        // ---------------- reset then idle ----------------
        tick();
        tick();
        clockRst = 1'b0;
        tick();
        tick();
        check("idle_count",    32'(count),    32'd0);
        check("idle_rdValid",  32'(rdValid),  32'd0);
        check("idle_rdData",   32'(rdData),   32'd0);
        check("idle_irq",      32'(irq),      32'd0);
        check("idle_overflow", 32'(overflow), 32'd0);

        // ---------------- coalesce at threshold 2 ----------------
        evtValid = 1'b1; evtData = 8'hA1;
        tick();
        check("c2_count1", 32'(count),  32'd1);
        check("c2_head1",  32'(rdData), 32'hA1);
        check("c2_irq1",   32'(irq),    32'd0);
        evtData = 8'hB2;
        tick();
        check("c2_count2",    32'(count),  32'd2);
        check("c2_head2",     32'(rdData), 32'hA1);
        check("c2_irq_lag",   32'(irq),    32'd0);
        evtValid = 1'b0;
        tick();
        check("c2_irq_set",   32'(irq),    32'd1);
        check("c2_pop1_data", 32'(rdData), 32'hA1);
        rdReq = 1'b1;
        tick();
        check("c2_pop2_data", 32'(rdData), 32'hB2);
        check("c2_count_p1",  32'(count),  32'd1);
        tick();
        rdReq = 1'b0;
        check("c2_count_p2",  32'(count),  32'd0);
        check("c2_empty_data",32'(rdData), 32'd0);
        check("c2_irq_clr",   32'(irq),    32'd0);

        // ---------------- fill, drop, drain, clear ----------------
        evtValid = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            evtData = 8'(i);
            tick();
        end
        check("ov_full_count", 32'(count), 32'd4);
        evtData = 8'h05;
        tick();
        evtValid = 1'b0;
        check("ov_drop_count", 32'(count),    32'd4);
        check("ov_flag_set",   32'(overflow), 32'd1);
        rdReq = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            check("ov_drain_data", 32'(rdData), 32'(i));
            tick();
        end
        rdReq = 1'b0;
        check("ov_drain_count", 32'(count),    32'd0);
        check("ov_flag_held",   32'(overflow), 32'd1);
        ovfClr = 1'b1;
        tick();
        ovfClr = 1'b0;
        check("ov_flag_clr",    32'(overflow), 32'd0);

        // ---------------- full with push and pop together (wrap) ----------------
        evtValid = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            evtData = 8'(i);
            tick();
        end
        evtData = 8'h05;
        rdReq   = 1'b1;
        tick();
        evtValid = 1'b0;
        check("fp_count",    32'(count),    32'd4);
        check("fp_no_ovf",   32'(overflow), 32'd0);
        for (int i = 2; i <= 5; i++) begin
            check("fp_drain_data", 32'(rdData), 32'(i));
            tick();
        end
        rdReq = 1'b0;
        check("fp_empty", 32'(count), 32'd0);

        // ---------------- drop with simultaneous clear, then async reset ----------------
        evtValid = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            evtData = 8'(8'h10 + i);
            tick();
        end
        evtData = 8'h99;
        ovfClr  = 1'b1;
        tick();
        evtValid = 1'b0;
        check("sw_set_wins", 32'(overflow), 32'd1);
        tick();
        ovfClr = 1'b0;
        check("sw_cleared",  32'(overflow), 32'd0);
        rdReq = 1'b1;
        tick();
        rdReq = 1'b0;
        check("mr_count3",   32'(count),  32'd3);
        check("mr_head",     32'(rdData), 32'h12);
        check("mr_irq_pre",  32'(irq),    32'd1);
        evtData = 8'h7E; ovfClr = 1'b0;
        #2;
        clockRst = 1'b1;
        #1;
        check("mr_count",    32'(count),    32'd0);
        check("mr_rdValid",  32'(rdValid),  32'd0);
        check("mr_rdData",   32'(rdData),   32'd0);
        check("mr_irq",      32'(irq),      32'd0);
        check("mr_overflow", 32'(overflow), 32'd0);
        tick();
        clockRst = 1'b0;
        tick();

        // ---------------- threshold zero, empty pop ----------------
        coalThresh = 3'd0;
        evtValid = 1'b1; evtData = 8'h3C;
        tick();
        evtValid = 1'b0;
        check("t0_count",   32'(count), 32'd1);
        check("t0_irq_lag", 32'(irq),   32'd0);
        tick();
        check("t0_irq_set", 32'(irq),   32'd1);
        rdReq = 1'b1;
        tick();
        check("t0_popped",  32'(count), 32'd0);
        tick();
        tick();
        rdReq = 1'b0;
        check("ep_count",   32'(count),   32'd0);
        check("ep_rdValid", 32'(rdValid), 32'd0);
        check("ep_irq",     32'(irq),     32'd0);
        evtValid = 1'b1; evtData = 8'h77;
        tick();
        evtValid = 1'b0;
        check("ep_count1",  32'(count),  32'd1);
        check("ep_head",    32'(rdData), 32'h77);
        rdReq = 1'b1;
        tick();
        rdReq = 1'b0;
        tick();
        check("ep_drained", 32'(count), 32'd0);
        check("ep_irq_off", 32'(irq),   32'd0);

        // ---------------- timeout interrupt ----------------
        coalThresh = 3'd4;
        tick();
        evtValid = 1'b1; evtData = 8'h5A;
        tick();                       // edge N
        evtValid = 1'b0;
        for (int k = 1; k <= TIMEOUT; k++) begin
            tick();                   // edges N+1 .. N+TIMEOUT
            check("to_irq_quiet", 32'(irq), 32'd0);
        end
        tick();                       // edge N+TIMEOUT+1
`ifdef UCTL_EVTQ_TIMEOUT_EN
        check("to_irq_fire", 32'(irq), 32'd1);
`else
        check("to_irq_none", 32'(irq), 32'd0);
`endif
        check("to_count", 32'(count), 32'd1);
        rdReq = 1'b1;
        tick();
        rdReq = 1'b0;
        check("to_popped", 32'(count), 32'd0);
        tick();
        check("to_irq_off", 32'(irq), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule
`default_nettype wire
